// File: rtl/frm_tx_pkg.sv
// Shared types and helpers for the frame transmit sequencer.
package frm_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TX   = 2'd1,
        GAP  = 2'd2
    } frm_tx_state_t;

    localparam int BYTE_W = 8;
    localparam int GAP_W  = 16;

    // Maps a send-order position onto the byte slot of the frame register.
    function automatic int byte_sel(input int idx, input logic msb_first, input int num_bytes);
        int slot;
        if (msb_first) begin
            slot = num_bytes - 32'sd1 - idx;
        end else begin
            slot = idx;
        end
        return slot;
    endfunction

endpackage

// File: rtl/frm_tx_seq_gap_timer.sv
// Loadable down-counter timing the idle gap between bytes of a frame.
module gap_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: reload on request, otherwise count down and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != {W{1'b0}}) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the last gap cycle so the next byte's trmt lands right after it.
    assign expired_o = (count_q == W'(1));

endmodule

// File: rtl/frm_tx_seq.sv
// Frame transmit sequencer: captures a multi-byte frame and hands it to the UART
// transmitter one byte at a time using the trmt/tx_done handshake.
module frm_tx_seq
    import frm_tx_pkg::*;
#(
    parameter int NUM_BYTES  = 2,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0,
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          snd_frm,
    input  logic [BYTE_W*NUM_BYTES-1:0]   frm_data,
    input  logic                          abort,
    input  logic                          tx_done,
    output logic                          trmt,
    output logic [BYTE_W-1:0]             tx_data,
    output logic [IDX_W-1:0]              byte_idx,
    output logic                          busy,
    output logic                          frm_cmplt,
    output logic                          frm_drop
);

    localparam int               FRAME_W  = BYTE_W * NUM_BYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    frm_tx_state_t      state_q;
    logic [FRAME_W-1:0] frame_q;
    logic [IDX_W-1:0]   byte_idx_q;
    logic [BYTE_W-1:0]  tx_data_q;
    logic               trmt_q;
    logic               busy_q;
    logic               frm_cmplt_q;
    logic               frm_drop_q;

    logic [IDX_W-1:0]   idx_inc_s;
    logic               done_ok_s;
    logic               last_byte_s;
    logic               gap_load_s;
    logic               gap_expired_s;

    function automatic logic [BYTE_W-1:0] pick_byte(input logic [FRAME_W-1:0] frm,
                                                    input logic [IDX_W-1:0]   idx);
        int slot;
        slot = byte_sel(int'(idx), MSB_FIRST, NUM_BYTES);
        return BYTE_W'(frm >> (BYTE_W * slot));
    endfunction

    // Handshake decode; a tx_done coinciding with our own trmt belongs to an earlier byte.
    always_comb begin
        done_ok_s   = (state_q == TX) && tx_done && !trmt_q && !abort;
        last_byte_s = (byte_idx_q == LAST_IDX);
        if (last_byte_s) begin
            idx_inc_s = byte_idx_q;
        end else begin
            idx_inc_s = byte_idx_q + IDX_W'(1);
        end
        gap_load_s  = done_ok_s && !last_byte_s && (GAP_CYCLES != 32'sd0);
    end

    gap_timer #(
        .W(GAP_W)
    ) u_gap_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (gap_load_s),
        .value_i   (GAP_LOAD),
        .expired_o (gap_expired_s)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_q     <= {FRAME_W{1'b0}};
            byte_idx_q  <= {IDX_W{1'b0}};
            tx_data_q   <= {BYTE_W{1'b0}};
            trmt_q      <= 1'b0;
            busy_q      <= 1'b0;
            frm_cmplt_q <= 1'b0;
            frm_drop_q  <= 1'b0;
        end else begin
            trmt_q     <= 1'b0;
            frm_drop_q <= snd_frm && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (snd_frm && !abort) begin
                        frame_q     <= frm_data;
                        byte_idx_q  <= {IDX_W{1'b0}};
                        tx_data_q   <= pick_byte(frm_data, {IDX_W{1'b0}});
                        frm_cmplt_q <= 1'b0;
                        trmt_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= TX;
                    end else begin
                        busy_q      <= 1'b0;
                    end
                end
                TX: begin
                    if (abort) begin
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (done_ok_s && last_byte_s) begin
                        frm_cmplt_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (gap_load_s) begin
                        byte_idx_q  <= idx_inc_s;
                        state_q     <= GAP;
                    end else if (done_ok_s) begin
                        byte_idx_q  <= idx_inc_s;
                        tx_data_q   <= pick_byte(frame_q, idx_inc_s);
                        trmt_q      <= 1'b1;
                    end else begin
                        busy_q      <= 1'b1;
                    end
                end
                GAP: begin
                    if (abort) begin
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (gap_expired_s) begin
                        tx_data_q   <= pick_byte(frame_q, byte_idx_q);
                        trmt_q      <= 1'b1;
                        state_q     <= TX;
                    end else begin
                        busy_q      <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign trmt      = trmt_q;
    assign tx_data   = tx_data_q;
    assign byte_idx  = byte_idx_q;
    assign busy      = busy_q;
    assign frm_cmplt = frm_cmplt_q;
    assign frm_drop  = frm_drop_q;

endmodule

// File: tb/tb_frm_tx_seq.sv
// Directed self-checking bench for frm_tx_seq across three parameter sets.
module tb_frm_tx_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // a: 2 bytes, MSB first, no gap
    logic a_snd, a_abort, a_done, a_trmt, a_busy, a_cmplt, a_drop;
    logic [15:0] a_data;
    logic [7:0]  a_txd;
    logic [0:0]  a_idx;
    // b: 4 bytes, LSB first, 3-cycle gap
    logic b_snd, b_abort, b_done, b_trmt, b_busy, b_cmplt, b_drop;
    logic [31:0] b_data;
    logic [7:0]  b_txd;
    logic [1:0]  b_idx;
    // c: single byte
    logic c_snd, c_abort, c_done, c_trmt, c_busy, c_cmplt, c_drop;
    logic [7:0]  c_data;
    logic [7:0]  c_txd;
    logic [0:0]  c_idx;

    frm_tx_seq #(.NUM_BYTES(2), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .snd_frm(a_snd), .frm_data(a_data), .abort(a_abort),
        .tx_done(a_done), .trmt(a_trmt), .tx_data(a_txd), .byte_idx(a_idx),
        .busy(a_busy), .frm_cmplt(a_cmplt), .frm_drop(a_drop));

    frm_tx_seq #(.NUM_BYTES(4), .MSB_FIRST(1'b0), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .snd_frm(b_snd), .frm_data(b_data), .abort(b_abort),
        .tx_done(b_done), .trmt(b_trmt), .tx_data(b_txd), .byte_idx(b_idx),
        .busy(b_busy), .frm_cmplt(b_cmplt), .frm_drop(b_drop));

    frm_tx_seq #(.NUM_BYTES(1), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .snd_frm(c_snd), .frm_data(c_data), .abort(c_abort),
        .tx_done(c_done), .trmt(c_trmt), .tx_data(c_txd), .byte_idx(c_idx),
        .busy(c_busy), .frm_cmplt(c_cmplt), .frm_drop(c_drop));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_snd = 1'b0; a_abort = 1'b0; a_done = 1'b0; a_data = 16'h0000;
        b_snd = 1'b0; b_abort = 1'b0; b_done = 1'b0; b_data = 32'h0000_0000;
        c_snd = 1'b0; c_abort = 1'b0; c_done = 1'b0; c_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({a_trmt, a_busy, a_cmplt, a_drop, a_txd, a_idx} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_a: got %b expected 0", {a_trmt, a_busy, a_cmplt, a_drop, a_txd, a_idx});
        end
        tests_run++;
        if ({b_trmt, b_busy, b_cmplt, b_drop, b_txd, b_idx, c_trmt, c_busy, c_txd} !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_bc: got %b expected 0", {b_trmt, b_busy, b_cmplt, b_drop, b_txd, b_idx, c_trmt, c_busy, c_txd});
        end
        rst_n = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({a_trmt, a_busy, b_trmt, c_trmt} !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got %b expected 0000", {a_trmt, a_busy, b_trmt, c_trmt});
        end
    endtask

    task automatic test_basic2();
        a_snd = 1'b1; a_data = 16'hA55A;
        tick();
        a_snd = 1'b0;
        tests_run++;
        if ({a_trmt, a_busy, a_txd, a_idx} !== {1'b1, 1'b1, 8'hA5, 1'b0}) begin
            tests_failed++;
            $display("FAIL basic2_byte0: got trmt=%b busy=%b txd=%h idx=%0d expected 1 1 a5 0", a_trmt, a_busy, a_txd, a_idx);
        end
        tick();
        tick();
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        tests_run++;
        if ({a_trmt, a_txd, a_idx} !== {1'b1, 8'h5A, 1'b1}) begin
            tests_failed++;
            $display("FAIL basic2_byte1: got trmt=%b txd=%h idx=%0d expected 1 5a 1", a_trmt, a_txd, a_idx);
        end
        tick();
        tick();
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        tests_run++;
        if ({a_cmplt, a_busy, a_trmt} !== 3'b100) begin
            tests_failed++;
            $display("FAIL basic2_cmplt: got cmplt=%b busy=%b trmt=%b expected 1 0 0", a_cmplt, a_busy, a_trmt);
        end
        tick();
        tests_run++;
        if (a_cmplt !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic2_cmplt_hold: got %b expected 1", a_cmplt);
        end
    endtask

    task automatic test_gap4();
        logic [7:0] exp_b [4];
        int pulses;
        int gap;
        exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
        pulses = 0;
        b_snd = 1'b1; b_data = 32'h11223344;
        tick();
        b_snd = 1'b0; b_data = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            if (b_trmt === 1'b1) pulses++;
            tests_run++;
            if ({b_trmt, b_txd, b_idx} !== {1'b1, exp_b[k], 2'(k)}) begin
                tests_failed++;
                $display("FAIL gap4_byte%0d: got trmt=%b txd=%h idx=%0d expected 1 %h %0d", k, b_trmt, b_txd, b_idx, exp_b[k], k);
            end
            tick();
            tick();
            b_done = 1'b1;
            tick();
            b_done = 1'b0;
            if (k < 3) begin
                if (k == 0) begin
                    tests_run++;
                    if (b_busy !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL gap4_busy_in_gap: got %b expected 1", b_busy);
                    end
                end
                gap = 0;
                while (b_trmt !== 1'b1 && gap < 20) begin
                    gap++;
                    tick();
                end
                tests_run++;
                if (gap != 3) begin
                    tests_failed++;
                    $display("FAIL gap4_gap%0d: got %0d low cycles expected 3", k, gap);
                end
            end
        end
        tests_run++;
        if ({b_cmplt, b_busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL gap4_cmplt: got cmplt=%b busy=%b expected 1 0", b_cmplt, b_busy);
        end
        repeat (5) begin
            tick();
            if (b_trmt === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 4) begin
            tests_failed++;
            $display("FAIL gap4_pulses: got %0d expected 4", pulses);
        end
    endtask

    task automatic test_drop();
        int extra;
        a_snd = 1'b1; a_data = 16'hC33C;
        tick();
        a_snd = 1'b0;
        tests_run++;
        if ({a_trmt, a_txd, a_cmplt} !== {1'b1, 8'hC3, 1'b0}) begin
            tests_failed++;
            $display("FAIL drop_start: got trmt=%b txd=%h cmplt=%b expected 1 c3 0", a_trmt, a_txd, a_cmplt);
        end
        tick();
        a_snd = 1'b1; a_data = 16'h1234;
        tick();
        a_snd = 1'b0;
        tests_run++;
        if ({a_drop, a_busy, a_trmt} !== 3'b110) begin
            tests_failed++;
            $display("FAIL drop_mid: got drop=%b busy=%b trmt=%b expected 1 1 0", a_drop, a_busy, a_trmt);
        end
        tick();
        tests_run++;
        if (a_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_pulse_width: got %b expected 0", a_drop);
        end
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        tests_run++;
        if ({a_trmt, a_txd} !== {1'b1, 8'h3C}) begin
            tests_failed++;
            $display("FAIL drop_frame_kept: got trmt=%b txd=%h expected 1 3c", a_trmt, a_txd);
        end
        tick();
        a_done = 1'b1; a_snd = 1'b1;
        tick();
        a_done = 1'b0; a_snd = 1'b0;
        tests_run++;
        if ({a_cmplt, a_drop, a_busy} !== 3'b110) begin
            tests_failed++;
            $display("FAIL drop_final: got cmplt=%b drop=%b busy=%b expected 1 1 0", a_cmplt, a_drop, a_busy);
        end
        extra = 0;
        repeat (5) begin
            tick();
            if (a_trmt === 1'b1) extra++;
        end
        tests_run++;
        if (extra != 0 || a_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_no_extra: got trmt_count=%0d drop=%b expected 0 0", extra, a_drop);
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp_f [4];
        int w;
        int cnt;
        exp_f[0] = 8'h88; exp_f[1] = 8'h77; exp_f[2] = 8'h66; exp_f[3] = 8'h55;
        b_snd = 1'b1; b_data = 32'hA1B2C3D4;
        tick();
        b_snd = 1'b0;
        tests_run++;
        if ({b_cmplt, b_txd} !== {1'b0, 8'hD4}) begin
            tests_failed++;
            $display("FAIL abort_start: got cmplt=%b txd=%h expected 0 d4", b_cmplt, b_txd);
        end
        tick();
        tick();
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        w = 0;
        while (b_trmt !== 1'b1 && w < 20) begin
            w++;
            tick();
        end
        tests_run++;
        if ({b_trmt, b_txd, b_idx} !== {1'b1, 8'hC3, 2'd1}) begin
            tests_failed++;
            $display("FAIL abort_byte1: got trmt=%b txd=%h idx=%0d expected 1 c3 1", b_trmt, b_txd, b_idx);
        end
        tick();
        b_abort = 1'b1;
        tick();
        b_abort = 1'b0;
        tests_run++;
        if ({b_busy, b_trmt, b_cmplt} !== 3'b000) begin
            tests_failed++;
            $display("FAIL abort_idle: got busy=%b trmt=%b cmplt=%b expected 0 0 0", b_busy, b_trmt, b_cmplt);
        end
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        cnt = 0;
        repeat (10) begin
            tick();
            if (b_trmt === 1'b1) cnt++;
        end
        tests_run++;
        if (cnt != 0 || b_cmplt !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_quiet: got trmt_count=%0d cmplt=%b expected 0 0", cnt, b_cmplt);
        end
        b_snd = 1'b1; b_data = 32'h55667788;
        tick();
        b_snd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (b_trmt !== 1'b1 && w < 20) begin
                w++;
                tick();
            end
            tests_run++;
            if ({b_trmt, b_txd} !== {1'b1, exp_f[k]}) begin
                tests_failed++;
                $display("FAIL abort_fresh_byte%0d: got trmt=%b txd=%h expected 1 %h", k, b_trmt, b_txd, exp_f[k]);
            end
            tick();
            tick();
            b_done = 1'b1;
            tick();
            b_done = 1'b0;
        end
        tests_run++;
        if ({b_cmplt, b_busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL abort_fresh_cmplt: got cmplt=%b busy=%b expected 1 0", b_cmplt, b_busy);
        end
    endtask

    task automatic test_reset_mid_gap();
        int cnt;
        b_snd = 1'b1; b_data = 32'hCAFEF00D;
        tick();
        b_snd = 1'b0;
        tick();
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        tests_run++;
        if ({b_busy, b_trmt, b_idx} !== {1'b1, 1'b0, 2'd1}) begin
            tests_failed++;
            $display("FAIL rstgap_in_gap: got busy=%b trmt=%b idx=%0d expected 1 0 1", b_busy, b_trmt, b_idx);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({b_busy, b_trmt, b_cmplt, b_drop, b_txd, b_idx} !== 14'd0) begin
            tests_failed++;
            $display("FAIL rstgap_async: got %b expected 0", {b_busy, b_trmt, b_cmplt, b_drop, b_txd, b_idx});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            tick();
            if (b_trmt === 1'b1) cnt++;
        end
        tests_run++;
        if (cnt != 0 || b_busy !== 1'b0 || b_cmplt !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstgap_after: got trmt_count=%0d busy=%b cmplt=%b expected 0 0 0", cnt, b_busy, b_cmplt);
        end
    endtask

    task automatic test_single();
        c_snd = 1'b1; c_data = 8'h7E;
        tick();
        c_snd = 1'b0;
        tests_run++;
        if ({c_trmt, c_txd, c_idx, c_busy} !== {1'b1, 8'h7E, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL single_start: got trmt=%b txd=%h idx=%0d busy=%b expected 1 7e 0 1", c_trmt, c_txd, c_idx, c_busy);
        end
        c_done = 1'b1;
        tick();
        c_done = 1'b0;
        tests_run++;
        if ({c_busy, c_cmplt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_done_ignored: got busy=%b cmplt=%b expected 1 0", c_busy, c_cmplt);
        end
        repeat (4) tick();
        c_done = 1'b1;
        tick();
        c_done = 1'b0;
        tests_run++;
        if ({c_cmplt, c_busy, c_trmt} !== 3'b100) begin
            tests_failed++;
            $display("FAIL single_cmplt: got cmplt=%b busy=%b trmt=%b expected 1 0 0", c_cmplt, c_busy, c_trmt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic2();
        test_gap4();
        test_drop();
        test_abort();
        test_reset_mid_gap();
        test_single();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
